// File: rtl/fetch_queue.sv
// Dual-issue fetch queue: a circular buffer that accepts fetch pairs and presents
// the two oldest {pc, instr} entries to decode.
module fetch_queue #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         instrf,
    input  logic [WIDTH-1:0]         instrf2,
    input  logic [WIDTH-1:0]         pcf,
    input  logic                     validf,
    input  logic                     flushd,
    input  logic [1:0]               popd,
    output logic                     stallf,
    output logic [WIDTH-1:0]         instrd,
    output logic [WIDTH-1:0]         instrd2,
    output logic [WIDTH-1:0]         pcd,
    output logic [WIDTH-1:0]         pcd2,
    output logic                     validd,
    output logic                     validd2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     underrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] instr;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic            r_underrun;

    logic [AW-1:0]   w_head1;
    logic [AW-1:0]   w_tail1;
    logic [CW-1:0]   w_pop_req;
    logic [CW-1:0]   w_pop;
    logic [CW-1:0]   w_push_amt;
    logic            w_push;
    entry_t          w_rd0;
    entry_t          w_rd1;

    assign w_head1 = r_head + AW'(1);
    assign w_tail1 = r_tail + AW'(1);

    // Stall looks only at registered occupancy so fetch never sees a pop-dependent path.
    assign stallf = (r_count > CW'(DEPTH - 2));
    assign w_push = validf & ~stallf;
    assign w_push_amt = w_push ? CW'(2) : CW'(0);

    always_comb begin
        w_pop_req = CW'(0);
        case (popd)
            2'd0:    w_pop_req = CW'(0);
            2'd1:    w_pop_req = CW'(1);
            default: w_pop_req = CW'(2);
        endcase
    end

    // Pop is bounded by occupancy before this cycle's push.
    assign w_pop = (w_pop_req > r_count) ? r_count : w_pop_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_underrun <= 1'b0;
        end else if (flushd) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_head     <= r_head + w_pop[AW-1:0];
            r_tail     <= r_tail + w_push_amt[AW-1:0];
            r_count    <= r_count + w_push_amt - w_pop;
            r_underrun <= (w_pop_req > r_count);
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!reset && !flushd && w_push) begin
            r_mem[r_tail]  <= '{pc: pcf, instr: instrf};
            r_mem[w_tail1] <= '{pc: pcf + WIDTH'(4), instr: instrf2};
        end
    end

    assign w_rd0    = r_mem[r_head];
    assign w_rd1    = r_mem[w_head1];
    assign instrd   = w_rd0.instr;
    assign pcd      = w_rd0.pc;
    assign instrd2  = w_rd1.instr;
    assign pcd2     = w_rd1.pc;
    assign validd   = (r_count >= CW'(1));
    assign validd2  = (r_count >= CW'(2));
    assign count    = r_count;
    assign underrun = r_underrun;
endmodule
